discrete_mul_arbiter: RTL

Time-shares one signed Q14 fixed-point multiplier among NUM_REQ discrete-audio stages: RC filters, VCO control scaling and mixer gains. Each stage gets at most one multiply per audio sample frame, and frames are delimited by audio_clk_en. The block sits between the per-sample filter stages and a single shared multiplier pipeline, and removes per-stage DSP multipliers from the sound boards.

---
 rtl/discrete_pkg.sv | 32 +++
 rtl/discrete_mul_arbiter_if.sv | 25 ++
 rtl/q14_sat_mul.sv | 59 +++++
 rtl/discrete_mul_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// Shared Q14 fixed-point types, limits and arbiter state encoding for the
// discrete-audio blocks (filters, VCO scaling, mixers).
package discrete_pkg;

  localparam int Q_SHIFT      = 14;
  localparam int V_FULL_SCALE = 12;

  typedef logic signed [15:0] q14_t;

  localparam q14_t SAT_MAX = 16'sh7FFF;
  localparam q14_t SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ARBITRATE  = 2'd1,
    DRAIN      = 2'd2
  } arb_state_t;

  // Arithmetic shift of a full 32-bit product, then clamp into the Q14 range.
  function automatic q14_t sat_shift(input logic signed [31:0] prod, input int shift);
    logic signed [31:0] sh;
    sh = prod >>> shift;
    if (sh > 32'sd32767) begin
      return SAT_MAX;
    end else if (sh < -32'sd32768) begin
      return SAT_MIN;
    end else begin
      return sh[15:0];
    end
  endfunction

endpackage

// File: rtl/discrete_mul_arbiter_if.sv
// Request/operand/result bundle between the audio stages and the shared multiplier.
interface discrete_mul_arbiter_if #(parameter int NUM_REQ = 4);
  import discrete_pkg::*;

  logic                   audio_clk_en;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*16-1:0]  a_in;
  logic [NUM_REQ*16-1:0]  b_in;
  logic [NUM_REQ-1:0]     gnt;
  q14_t                   result;
  logic [NUM_REQ-1:0]     result_valid;
  logic                   frame_done;
  logic                   overrun;

  modport master (
    output audio_clk_en, req, a_in, b_in,
    input  gnt, result, result_valid, frame_done, overrun
  );

  modport slave (
    input  audio_clk_en, req, a_in, b_in,
    output gnt, result, result_valid, frame_done, overrun
  );

endinterface

// File: rtl/q14_sat_mul.sv
// Two-stage signed Q14 multiplier: stage 1 registers operands and an owner tag,
// stage 2 forms the product, shifts it back to Q14 and saturates.
module q14_sat_mul
  import discrete_pkg::*;
#(
  parameter int SHIFT = Q_SHIFT,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  q14_t             a,
  input  q14_t             b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             busy,
  output logic [TAG_W-1:0] out_tag,
  output q14_t             result
);

  q14_t               a_q;
  q14_t               b_q;
  logic [TAG_W-1:0]   tag_q;
  logic               v_q;
  logic signed [31:0] prod;

  assign prod = a_q * b_q;
  assign busy = v_q;

  // Stage 1: capture operands and owner tag of the granted stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= 1'b0;
      a_q   <= 16'sd0;
      b_q   <= 16'sd0;
      tag_q <= {TAG_W{1'b0}};
    end else begin
      v_q   <= in_valid;
      tag_q <= in_valid ? in_tag : {TAG_W{1'b0}};
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  // Stage 2: product, shift and saturate; result keeps its value between outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tag <= {TAG_W{1'b0}};
      result  <= 16'sd0;
    end else begin
      out_tag <= v_q ? tag_q : {TAG_W{1'b0}};
      if (v_q) begin
        result <= sat_shift(prod, SHIFT);
      end
    end
  end

endmodule

// File: rtl/discrete_mul_arbiter.sv
// Round-robin arbiter that time-shares one Q14 multiplier among the audio stages,
// granting each stage at most one multiply per audio frame.
module discrete_mul_arbiter
  import discrete_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SHIFT      = Q_SHIFT,
  parameter int PIPE_DEPTH = 2
) (
  input logic                    clk,
  input logic                    I_RST,
  discrete_mul_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t            state;
  arb_state_t            state_n;
  logic [NUM_REQ-1:0]    served;
  logic [NUM_REQ-1:0]    served_eff;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    pick_oh;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      pick;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  do_grant;
  logic                  set_overrun;
  logic                  frame_done_n;
  logic                  frame_done_q;
  logic                  overrun_q;
  logic                  mul_busy;
  logic [PIPE_DEPTH-1:0] inflight;
  q14_t                  a_sel;
  q14_t                  b_sel;

  // First eligible index at or after the start position, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
    return sel;
  endfunction

  // A strobe starts a fresh frame, so the served mask is ignored in that cycle.
  assign served_eff = bus.audio_clk_en ? {NUM_REQ{1'b0}} : served;
  assign elig       = bus.req & ~served_eff;
  assign pick       = rr_pick(elig, ptr);
  assign pick_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  assign inflight   = {mul_busy, |gnt_q};

  assign a_sel = bus.a_in[{gnt_idx, 4'b0000} +: 16];
  assign b_sel = bus.b_in[{gnt_idx, 4'b0000} +: 16];

  // FSM state register
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state <= WAIT_FRAME;
    end else begin
      state <= state_n;
    end
  end

  // Next state, grant decision, overrun detection and frame completion
  always_comb begin
    state_n      = state;
    do_grant     = 1'b0;
    set_overrun  = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (bus.audio_clk_en) begin
          state_n  = ARBITRATE;
          do_grant = |elig;
        end else begin
          state_n = WAIT_FRAME;
        end
      end
      ARBITRATE: begin
        if (bus.audio_clk_en) begin
          set_overrun = |(bus.req & ~served);
          do_grant    = |elig;
          state_n     = ARBITRATE;
        end else if (|elig) begin
          do_grant = 1'b1;
          state_n  = ARBITRATE;
        end else begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.audio_clk_en) begin
          set_overrun = |(bus.req & ~served);
          do_grant    = |elig;
          state_n     = ARBITRATE;
        end else if (|elig) begin
          do_grant = 1'b1;
          state_n  = ARBITRATE;
        end else if (inflight == {PIPE_DEPTH{1'b0}}) begin
          frame_done_n = 1'b1;
          state_n      = WAIT_FRAME;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n = WAIT_FRAME;
      end
    endcase
  end

  // Grant pulse, served mask, round-robin pointer and status flags
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      gnt_q        <= {NUM_REQ{1'b0}};
      gnt_idx      <= {IDX_W{1'b0}};
      served       <= {NUM_REQ{1'b0}};
      ptr          <= {IDX_W{1'b0}};
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      gnt_q        <= do_grant ? pick_oh : {NUM_REQ{1'b0}};
      served       <= served_eff | (do_grant ? pick_oh : {NUM_REQ{1'b0}});
      frame_done_q <= frame_done_n;
      if (do_grant) begin
        gnt_idx <= pick;
        ptr     <= (pick == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : pick + IDX_W'(1);
      end
      if (set_overrun) begin
        overrun_q <= 1'b1;
      end
    end
  end

  q14_sat_mul #(
    .SHIFT (SHIFT),
    .TAG_W (NUM_REQ)
  ) u_mul (
    .clk      (clk),
    .rst      (I_RST),
    .in_valid (|gnt_q),
    .a        (a_sel),
    .b        (b_sel),
    .in_tag   (gnt_q),
    .busy     (mul_busy),
    .out_tag  (bus.result_valid),
    .result   (bus.result)
  );

  assign bus.gnt        = gnt_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule
